// File: rtl/mul_pkg.sv
// Shared constants and sideband type for the multiply completion stage.
//   MUL_W / HALF_W : full and half operand widths
//   MUL_LAT        : edges from accept to registered result (cell, A, B)
//   mul_side_t     : {valid, tag} sideband carried next to each operation
package mul_pkg;

  localparam int unsigned MUL_W     = 32;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned MUL_LAT   = 3;
  localparam int unsigned TAG_W_DEF = 5;

  // valid sits in the MSB so generic stage registers can find it
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
  } mul_side_t;

endpackage

// File: rtl/mul_stage_reg.sv
// One pipeline slot: sideband {valid, ...} plus data, frozen when en_i is low.
// Ports:
//   clk, rst_n  : clock, async active-low clear (all state to 0)
//   en_i        : advance enable (~stall)
//   flush_i     : clears the valid bit (MSB of side) at the next edge, even when frozen
//   side_d_i/_q_o : sideband in/out, MSB is the valid bit
//   data_d_i/_q_o : payload in/out, not touched by flush
module mul_stage_reg #(
  parameter int unsigned SIDE_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [SIDE_W-1:0] side_d_i,
  input  logic [DATA_W-1:0] data_d_i,
  output logic [SIDE_W-1:0] side_q_o,
  output logic [DATA_W-1:0] data_q_o
);

  logic              valid_q;
  logic [SIDE_W-2:0] meta_q;
  logic [DATA_W-1:0] data_q;

  // valid bit: flush beats enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= side_d_i[SIDE_W-1];
    end
  end

  // tag and data only move with the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      data_q <= '0;
    end else if (en_i) begin
      meta_q <= side_d_i[SIDE_W-2:0];
      data_q <= data_d_i;
    end
  end

  assign side_q_o = {valid_q, meta_q};
  assign data_q_o = data_q;

endmodule

// File: rtl/mul_cell_combine.sv
// Completion stage for the 16x16 partial-product multiply cell: reduces the
// three registered partial products to the low 32 bits of the 32x32 product.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_tag       : operation presented to the cell this cycle
//   in_ready, cell_en     : combinational ~stall (cell and all stages freeze together)
//   p1, p2, p3            : cell product registers (lo*lo, lo*hi, hi*lo)
//   flush                 : drop every in-flight operation and any same-cycle input
//   out_valid/out_ready   : result handshake
//   out_result, out_tag   : registered result and its tag
// The sideband struct fixes the tag width at mul_pkg::TAG_W_DEF; TAG_W must match it.
module mul_cell_combine
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             cell_en,
  input  logic [MUL_W-1:0] p1,
  input  logic [MUL_W-1:0] p2,
  input  logic [MUL_W-1:0] p3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MUL_W-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SIDE_W = $bits(mul_side_t);
  localparam int unsigned A_W    = MUL_W + HALF_W;

  logic              stall;
  logic              accept;
  mul_side_t         side_c_d, side_c_q, side_a_q, side_b_q;
  logic              data_c_unused;
  logic [A_W-1:0]    data_a_d, data_a_q;
  logic [HALF_W-1:0] mid_d, mid_a;
  logic [MUL_W-1:0]  lo_a, result_d, result_q;
  logic              unused_hi_bits;

  // handshake: a held result freezes the whole pipe including the cell
  assign stall    = side_b_q.valid & ~out_ready;
  assign in_ready = ~stall;
  assign cell_en  = ~stall;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    side_c_d       = '0;
    side_c_d.valid = accept;
    side_c_d.tag   = in_tag;
  end

  // stage C: sideband aligned with the cell's product registers
  mul_stage_reg #(.SIDE_W(SIDE_W), .DATA_W(1)) u_stage_c (
    .clk      (clk),
    .rst_n    (reset_n),
    .en_i     (~stall),
    .flush_i  (flush),
    .side_d_i (side_c_d),
    .data_d_i (1'b0),
    .side_q_o (side_c_q),
    .data_q_o (data_c_unused)
  );

  // stage A: only the low half of the cross terms reaches the low 32 bits
  assign mid_d    = p2[HALF_W-1:0] + p3[HALF_W-1:0];
  assign data_a_d = {p1, mid_d};

  mul_stage_reg #(.SIDE_W(SIDE_W), .DATA_W(A_W)) u_stage_a (
    .clk      (clk),
    .rst_n    (reset_n),
    .en_i     (~stall),
    .flush_i  (flush),
    .side_d_i (side_c_q),
    .data_d_i (data_a_d),
    .side_q_o (side_a_q),
    .data_q_o (data_a_q)
  );

  // stage B: final add, wraps modulo 2^32
  assign lo_a     = data_a_q[A_W-1:HALF_W];
  assign mid_a    = data_a_q[HALF_W-1:0];
  assign result_d = lo_a + {mid_a, {HALF_W{1'b0}}};

  mul_stage_reg #(.SIDE_W(SIDE_W), .DATA_W(MUL_W)) u_stage_b (
    .clk      (clk),
    .rst_n    (reset_n),
    .en_i     (~stall),
    .flush_i  (flush),
    .side_d_i (side_a_q),
    .data_d_i (result_d),
    .side_q_o (side_b_q),
    .data_q_o (result_q)
  );

  assign out_valid  = side_b_q.valid;
  assign out_tag    = side_b_q.tag;
  assign out_result = result_q;

  // upper cross-term bits only affect bits above 31
  assign unused_hi_bits = ^{p2[MUL_W-1:HALF_W], p3[MUL_W-1:HALF_W], data_c_unused};

endmodule

// File: tb/tb_mul_cell_combine.sv
// Directed bench for mul_cell_combine with a behavioural partial-product cell.
module tb_mul_cell_combine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [4:0]  in_tag;
  logic        in_ready;
  logic        cell_en;
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [31:0] src1, src2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // partial-product cell as the parent would instantiate it
  always_ff @(posedge clk) begin
    if (cell_en) begin
      p1 <= 32'(src1[15:0]) * 32'(src2[15:0]);
      p2 <= 32'(src1[15:0]) * 32'(src2[31:16]);
      p3 <= 32'(src1[31:16]) * 32'(src2[15:0]);
    end
  end

  mul_cell_combine #(.TAG_W(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_tag     (in_tag),
    .in_ready   (in_ready),
    .cell_en    (cell_en),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    in_valid = v;
    src1     = a;
    src2     = b;
    in_tag   = t;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0);
    step(); step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", out_result); end
    n_tests++; if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", out_tag); end
    reset_n = 1'b1;
    step();
    n_tests++; if (in_ready !== 1'b1 || cell_en !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got in_ready=%b cell_en=%b expected 1/1", in_ready, cell_en); end
  endtask

  task automatic test_basic();
    drive(1'b1, 32'h0001_2345, 32'h0000_0010, 5'd3);
    step();
    drive(1'b0, 32'h0, 32'h0, 5'd0);
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got valid=%b expected 0", out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'h0012_3450 || out_tag !== 5'd3)
      begin n_fail++; $display("FAIL basic_result: got v=%b r=%h t=%0d expected v=1 r=00123450 t=3", out_valid, out_result, out_tag); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    step();
    drive(1'b0, 32'h0, 32'h0, 5'd0);
    step(); step();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'h0000_0001 || out_tag !== 5'd7)
      begin n_fail++; $display("FAIL wrap_result: got v=%b r=%h t=%0d expected v=1 r=00000001 t=7", out_valid, out_result, out_tag); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1);
    step();
    drive(1'b1, 32'h8000_0000, 32'h0000_0002, 5'd2);
    step();
    drive(1'b0, 32'h0, 32'h0, 5'd0);
    step();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFEB || out_tag !== 5'd1)
      begin n_fail++; $display("FAIL b2b_first: got v=%b r=%h t=%0d expected v=1 r=ffffffeb t=1", out_valid, out_result, out_tag); end
    step();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'h0000_0000 || out_tag !== 5'd2)
      begin n_fail++; $display("FAIL b2b_second: got v=%b r=%h t=%0d expected v=1 r=00000000 t=2", out_valid, out_result, out_tag); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    logic [31:0] exp_r [4];
    logic [31:0] held_r;
    logic [4:0]  held_t;
    int in_idx, out_idx, stall_left;
    bit first_seen;
    op_a[0] = 32'h0000_0003; op_b[0] = 32'h0000_0005; exp_r[0] = 32'h0000_000F;
    op_a[1] = 32'h0001_0001; op_b[1] = 32'h0001_0001; exp_r[1] = 32'h0002_0001;
    op_a[2] = 32'h0000_1234; op_b[2] = 32'h0000_0100; exp_r[2] = 32'h0012_3400;
    op_a[3] = 32'h0002_0003; op_b[3] = 32'h0004_0005; exp_r[3] = 32'h0016_000F;
    in_idx = 0; out_idx = 0; stall_left = 0; first_seen = 1'b0;
    held_r = '0; held_t = '0;
    for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
      if (in_idx < 4) drive(1'b1, op_a[in_idx], op_b[in_idx], 5'(10 + in_idx));
      else drive(1'b0, 32'h0, 32'h0, 5'd0);
      #1;
      if (out_valid && !first_seen) begin
        first_seen = 1'b1; stall_left = 5; held_r = out_result; held_t = out_tag;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        n_tests++; if (in_ready !== 1'b0 || cell_en !== 1'b0)
          begin n_fail++; $display("FAIL stall_ready: got in_ready=%b cell_en=%b expected 0/0", in_ready, cell_en); end
        n_tests++; if (out_valid !== 1'b1 || out_result !== held_r || out_tag !== held_t)
          begin n_fail++; $display("FAIL stall_hold: got v=%b r=%h t=%0d expected v=1 r=%h t=%0d", out_valid, out_result, out_tag, held_r, held_t); end
        stall_left--;
      end else if (out_valid) begin
        n_tests++; if (out_result !== exp_r[out_idx] || out_tag !== 5'(10 + out_idx))
          begin n_fail++; $display("FAIL stall_order: got r=%h t=%0d expected r=%h t=%0d", out_result, out_tag, exp_r[out_idx], 10 + out_idx); end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      @(posedge clk);
      #1;
    end
    n_tests++; if (out_idx != 4) begin n_fail++; $display("FAIL stall_timeout: got %0d results expected 4", out_idx); end
    drive(1'b0, 32'h0, 32'h0, 5'd0);
    out_ready = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup: got valid=%b expected 0", out_valid); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0001, 32'h0000_0002, 5'd1); step();
    drive(1'b1, 32'h0000_0003, 32'h0000_0003, 5'd2); step();
    drive(1'b1, 32'h0000_0004, 32'h0000_0004, 5'd3); step();
    drive(1'b1, 32'h0000_0005, 32'h0000_0005, 5'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: cycle %0d got valid=%b tag=%0d expected 0", i, out_valid, out_tag); end
      step();
    end
    drive(1'b1, 32'h0000_0003, 32'h0000_0004, 5'd4); step();
    drive(1'b0, 32'h0, 32'h0, 5'd0); step(); step();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'h0000_000C || out_tag !== 5'd4)
      begin n_fail++; $display("FAIL flush_after: got v=%b r=%h t=%0d expected v=1 r=0000000c t=4", out_valid, out_result, out_tag); end
    step();
    // flush while stalled: the valid bits still clear
    drive(1'b1, 32'h0000_0006, 32'h0000_0007, 5'd5); step();
    drive(1'b0, 32'h0, 32'h0, 5'd0); step(); step();
    out_ready = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'h0000_002A)
      begin n_fail++; $display("FAIL flush_stall_hold: got v=%b r=%h expected v=1 r=0000002a", out_valid, out_result); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_stall: got valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0002, 32'h0000_0003, 5'd6); step();
    drive(1'b1, 32'h0000_0004, 32'h0000_0005, 5'd7); step();
    drive(1'b0, 32'h0, 32'h0, 5'd0); step();
    n_tests++; if (out_valid !== 1'b1 || out_result !== 32'h0000_0006)
      begin n_fail++; $display("FAIL rst_pre: got v=%b r=%h expected v=1 r=00000006", out_valid, out_result); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_result !== 32'h0)
      begin n_fail++; $display("FAIL rst_async: got v=%b r=%h expected v=0 r=00000000", out_valid, out_result); end
    step();
    reset_n = 1'b1;
    step();
    n_tests++; if (in_ready !== 1'b1 || cell_en !== 1'b1)
      begin n_fail++; $display("FAIL rst_ready: got in_ready=%b cell_en=%b expected 1/1", in_ready, cell_en); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale: cycle %0d got valid=%b expected 0", i, out_valid); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_cell_combine.md
# mul_cell_combine

Downstream completion stage for the Nios II multiply partial-product cell. It consumes the three registered 16×16 unsigned partial products (p1 = lo×lo, p2 = src1.lo×src2.hi, p3 = src1.hi×src2.lo) and reduces them to the low 32 bits of the 32×32 product over two pipeline stages. It owns the cell's register enable, carries a destination tag alongside each operation, and presents results through a valid/ready handshake with pipeline flush.

## Interface
Parameters:
- TAG_W, 5, width of the destination tag carried with each operation.

Ports:
- clk  input  1  single clock for the block and the partial-product cell.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands are presented to the cell this cycle.
- in_tag  input  TAG_W  destination tag for the presented operation.
- in_ready  output  1  block accepts an operation this cycle.
- cell_en  output  1  register enable driven to the partial-product cell.
- p1  input  32  src1[15:0]×src2[15:0], registered by the cell.
- p2  input  32  src1[15:0]×src2[31:16], registered by the cell.
- p3  input  32  src1[31:16]×src2[15:0], registered by the cell.
- flush  input  1  kill all in-flight operations.
- out_valid  output  1  result and out_tag are valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  32  low 32 bits of src1×src2. Signed and unsigned give the same value.
- out_tag  output  TAG_W  tag of the result.

## Operation
- stall = out_valid & ~out_ready.
- in_ready = ~stall.
- cell_en = ~stall. The cell and every stage freeze together while stalled.
- Accept = in_valid & in_ready & ~flush.
- Stage C (cell-aligned): v_c and tag_c are registered on accept. Their timing matches the cell's product registers.
- Stage A, registered when not stalled:
  - lo_a = p1.
  - mid_a[15:0] = p2[15:0] + p3[15:0]. The carry is discarded.
  - v_a = v_c and tag_a = tag_c.
- Stage B (output register), registered when not stalled:
  - out_result = lo_a + {mid_a, 16'h0}, modulo 2^32.
  - out_valid = v_a and out_tag = tag_a.
- flush:
  - v_c, v_a and out_valid clear at the next edge, regardless of stall.
  - Data registers are don't-care.
  - An in_valid in the same cycle is dropped.
- Bubbles: invalid slots advance normally. No reordering.
- Reset:
  - out_valid, v_c and v_a are 0.
  - out_result and out_tag are 0.
  - in_ready and cell_en are 1 one cycle after deassertion. Both are combinational on out_valid.
- Reset asserted mid-operation discards all in-flight operations with no output.

## Timing
- Operands accepted at edge T appear as out_valid=1 in cycle T+3.
- Latency is 3 edges: cell, A, B.
- Throughput is 1 operation per cycle with no stall. Back-to-back accepts produce back-to-back outputs.
- Stall: all state holds exactly while out_valid & ~out_ready.
  - out_result and out_tag are stable while stalled.
  - Stall release resumes with no lost or duplicated operation.
- Simultaneous flush and stall: flush wins for the valid bits. The stall condition clears on the next cycle.
- Simultaneous out_ready and a new accept: both proceed in the same cycle.

## Structure
- Shared package mul_pkg holds:
  - MUL_W = 32, HALF_W = 16 and MUL_LAT = 3.
  - A packed typedef for the {valid, tag} sideband.
- One natural sub-module: mul_stage_reg, a valid/tag/data register with async clear, enable (~stall) and flush-clear. It is instantiated for stages C, A and B.
- The partial-product cell is instantiated by the parent, not inside this block.

## Test plan
- src1=0x00012345, src2=0x00000010, tag=3 → out_result=0x00123450 and out_tag=3, three cycles after accept.
- src1=src2=0xFFFFFFFF → out_result=0x00000001. This exercises the discarded mid carry and the 32-bit wrap.
- src1=7, src2=0xFFFFFFFD → 0xFFFFFFEB. Then src1=0x80000000, src2=2 → 0x00000000, issued back-to-back and output back-to-back.
- Four back-to-back operations with out_ready=0 for 5 cycles once the first result appears:
  - in_ready=0 and cell_en=0 throughout.
  - Results emerge in order, exactly once each, after release.
- flush asserted with 3 operations in flight plus in_valid=1 in the same cycle → no out_valid for the next 4 cycles. The next accepted operation completes normally.
- reset_n pulsed low mid-stream with 2 operations in flight → out_valid=0 immediately and no stale result after release. in_ready=1 in the first cycle after deassertion.
